// File: rtl/lava_pkg.sv
// ---------------------------------------------------------------------------
// lava_pkg
// Shared definitions for the lava wall engine: the wall state encoding and
// the default screen geometry used by the engine and its testbench.
// ---------------------------------------------------------------------------
package lava_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DELAY    = 3'd1,
        ADVANCE  = 3'd2,
        HALT     = 3'd3,
        DISABLED = 3'd4
    } lava_state_t;

    localparam int SCREEN_W = 640;
    localparam int WALL_W   = 10;

endpackage

// File: rtl/boost_stack.sv
// ---------------------------------------------------------------------------
// boost_stack
// Saturating speed-boost step counter with a decay timer. Every accepted
// boost adds one step (up to MAX_STEPS) and restarts the decay timer; while
// steps are held and no boost arrives, one step is shed every DECAY_TICKS
// enabled ticks.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   clr          in   synchronous clear (level change), same effect as rst
//   tick_en      in   game tick that is allowed to advance state
//   boost_req    in   boost accepted on this tick (already qualified)
//   boost_steps  out  current number of boost steps
//   decay_strobe out  high on the tick where one step decays
// ---------------------------------------------------------------------------
module boost_stack #(
    parameter int SPD_W       = 4,
    parameter int MAX_STEPS   = 8,
    parameter int DECAY_TICKS = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tick_en,
    input  logic             boost_req,
    output logic [SPD_W-1:0] boost_steps,
    output logic             decay_strobe
);

    localparam int                DCY_W    = $clog2(DECAY_TICKS + 1);
    localparam logic [DCY_W-1:0]  DCY_LAST = DCY_W'(DECAY_TICKS - 1);
    localparam logic [SPD_W-1:0]  STEP_MAX = SPD_W'(MAX_STEPS);

    logic [DCY_W-1:0] decay_cnt;

    assign decay_strobe = tick_en && !boost_req && (boost_steps != '0)
                          && (decay_cnt == DCY_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            boost_steps <= '0;
            decay_cnt   <= '0;
        end else if (tick_en) begin
            if (boost_req) begin
                if (boost_steps != STEP_MAX)
                    boost_steps <= boost_steps + 1'b1;
                decay_cnt <= '0;
            end else if (boost_steps != '0) begin
                if (decay_strobe) begin
                    boost_steps <= boost_steps - 1'b1;
                    decay_cnt   <= '0;
                end else begin
                    decay_cnt <= decay_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lava_wall_engine.sv
// ---------------------------------------------------------------------------
// lava_wall_engine
// Left-to-right lava wall: waits for the first player input, holds off for
// DELAY_TICKS game ticks, then advances at a level-scaled speed plus any
// boost steps, clamping at the right edge of the screen. Reports a one-clk
// hit pulse on first contact and a sticky caught flag.
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | waiting for the first player input
// DELAY    | counting down the start delay, wall parked at 0
// ADVANCE  | wall moving right by lava_speed each tick
// HALT     | wall clamped at the right edge, still lethal
// DISABLED | wall not used on this level, x parked at 0
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   game_tick          one-cycle frame strobe; all motion happens on it
//   any_input_level    player input held
//   speed_boost_pulse  boost request, sampled on game_tick only
//   freeze             pause; all tick-driven state holds
//   player_x           player left edge
//   level              current level (change clears the engine)
//   lava_wall_x        wall left edge
//   lava_speed         effective speed, registered
//   lava_active        high in ADVANCE or HALT
//   hit_lava_wall      one-clk pulse on first contact
//   player_caught      sticky contact flag
// ---------------------------------------------------------------------------
module lava_wall_engine #(
    parameter int         X_W               = 10,
    parameter int         SCREEN_W          = lava_pkg::SCREEN_W,
    parameter int         WALL_W            = lava_pkg::WALL_W,
    parameter int         DELAY_TICKS       = 120,
    parameter int         SPD_W             = 4,
    parameter int         BASE_SPEED        = 1,
    parameter int         MAX_SPEED         = 8,
    parameter int         BOOST_DECAY_TICKS = 60,
    parameter logic [3:0] LEVEL_MASK        = 4'b0011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             game_tick,
    input  logic             any_input_level,
    input  logic             speed_boost_pulse,
    input  logic             freeze,
    input  logic [X_W-1:0]   player_x,
    input  logic [1:0]       level,
    output logic [X_W-1:0]   lava_wall_x,
    output logic [SPD_W-1:0] lava_speed,
    output logic             lava_active,
    output logic             hit_lava_wall,
    output logic             player_caught
);

    import lava_pkg::*;

    localparam int                XE        = X_W + 1;
    localparam int                DLY_W     = $clog2(DELAY_TICKS + 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(DELAY_TICKS - 1);
    localparam logic [XE-1:0]     WALL_WX   = XE'(WALL_W);
    localparam logic [XE-1:0]     SCREEN_WX = XE'(SCREEN_W);
    localparam logic [X_W-1:0]    X_STOP    = X_W'(SCREEN_W - WALL_W);
    localparam logic [SPD_W+1:0]  SPD_MAX   = (SPD_W + 2)'(MAX_SPEED);

    lava_state_t      state;
    logic [1:0]       level_q;
    logic [DLY_W-1:0] delay_cnt;
    logic [SPD_W-1:0] boost_steps;
    logic             decay_strobe_unused;

    logic             level_chg;
    logic             tick_en;
    logic             mask_en;
    logic             wall_on;
    logic             boost_req;
    logic [XE-1:0]    x_sum;
    logic             adv_halt;
    logic [XE-1:0]    x_post;
    logic [XE-1:0]    reach;
    logic             contact;
    logic [SPD_W+1:0] spd_raw;
    logic [SPD_W-1:0] spd_clamp;

    // Level change is seen combinationally against the registered level so
    // the clear lands on the same clk the new level first appears.
    assign level_chg = (level != level_q);
    assign tick_en   = game_tick && !freeze;
    assign mask_en   = LEVEL_MASK[level_q];
    assign wall_on   = (state == ADVANCE) || (state == HALT);
    assign boost_req = tick_en && speed_boost_pulse && wall_on;

    // One extra bit on every position sum keeps the edge compare honest
    // even when x + speed + WALL_W passes 2**X_W.
    assign x_sum    = {1'b0, lava_wall_x} + XE'(lava_speed);
    assign adv_halt = (x_sum + WALL_WX) >= SCREEN_WX;
    assign x_post   = (state == ADVANCE) ? (adv_halt ? {1'b0, X_STOP} : x_sum)
                                         : {1'b0, lava_wall_x};
    assign reach    = x_post + WALL_WX;
    assign contact  = reach >= {1'b0, player_x};

    assign spd_raw   = (SPD_W + 2)'(BASE_SPEED) + (SPD_W + 2)'(level_q)
                     + (SPD_W + 2)'(boost_steps);
    assign spd_clamp = (spd_raw > SPD_MAX) ? SPD_MAX[SPD_W-1:0]
                                           : spd_raw[SPD_W-1:0];

    assign lava_active = wall_on;

    boost_stack #(
        .SPD_W       (SPD_W),
        .MAX_STEPS   (MAX_SPEED),
        .DECAY_TICKS (BOOST_DECAY_TICKS)
    ) u_boost_stack (
        .clk          (clk),
        .rst          (rst),
        .clr          (level_chg),
        .tick_en      (tick_en),
        .boost_req    (boost_req),
        .boost_steps  (boost_steps),
        .decay_strobe (decay_strobe_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            level_q       <= 2'd0;
            delay_cnt     <= '0;
            lava_wall_x   <= '0;
            lava_speed    <= '0;
            hit_lava_wall <= 1'b0;
            player_caught <= 1'b0;
        end else begin
            level_q       <= level;
            lava_speed    <= spd_clamp;
            hit_lava_wall <= 1'b0;
            if (level_chg) begin
                state         <= IDLE;
                delay_cnt     <= '0;
                lava_wall_x   <= '0;
                player_caught <= 1'b0;
            end else if (tick_en) begin
                if (!mask_en) begin
                    state       <= DISABLED;
                    lava_wall_x <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (any_input_level) begin
                                state     <= DELAY;
                                delay_cnt <= '0;
                            end
                        end
                        DELAY: begin
                            delay_cnt <= delay_cnt + 1'b1;
                            if (delay_cnt == DLY_LAST)
                                state <= ADVANCE;
                        end
                        ADVANCE: begin
                            lava_wall_x <= x_post[X_W-1:0];
                            if (adv_halt)
                                state <= HALT;
                        end
                        HALT: begin
                        end
                        default: state <= IDLE;
                    endcase
                    if (wall_on && contact && !player_caught) begin
                        hit_lava_wall <= 1'b1;
                        player_caught <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lava_wall_engine.sv
module tb_lava_wall_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_tick;
    logic       any_input_level;
    logic       speed_boost_pulse;
    logic       freeze;
    logic [9:0] player_x;
    logic [1:0] level;
    logic [9:0] lava_wall_x;
    logic [3:0] lava_speed;
    logic       lava_active;
    logic       hit_lava_wall;
    logic       player_caught;

    int n_chk  = 0;
    int n_fail = 0;
    int hit_cnt = 0;
    int hit_base;

    always #5 clk = ~clk;

    lava_wall_engine dut (
        .clk               (clk),
        .rst               (rst),
        .game_tick         (game_tick),
        .any_input_level   (any_input_level),
        .speed_boost_pulse (speed_boost_pulse),
        .freeze            (freeze),
        .player_x          (player_x),
        .level             (level),
        .lava_wall_x       (lava_wall_x),
        .lava_speed        (lava_speed),
        .lava_active       (lava_active),
        .hit_lava_wall     (hit_lava_wall),
        .player_caught     (player_caught)
    );

    always @(negedge clk)
        if (hit_lava_wall === 1'b1) hit_cnt = hit_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One game tick followed by three idle clocks; returns #1 after an edge.
    task automatic tick(input logic inp, input logic boost, input logic frz);
        any_input_level   = inp;
        speed_boost_pulse = boost;
        freeze            = frz;
        game_tick         = 1'b1;
        @(posedge clk);
        #1;
        game_tick         = 1'b0;
        speed_boost_pulse = 1'b0;
        freeze            = 1'b0;
        any_input_level   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] lvl, input logic check_vals);
        rst   = 1'b1;
        level = lvl;
        repeat (2) @(posedge clk);
        #1;
        if (check_vals) begin
            chk("rst_x",      lava_wall_x,   0);
            chk("rst_speed",  lava_speed,    0);
            chk("rst_active", lava_active,   0);
            chk("rst_hit",    hit_lava_wall, 0);
            chk("rst_caught", player_caught, 0);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; game_tick = 0; any_input_level = 0; speed_boost_pulse = 0;
        freeze = 0; player_x = 10'd1023; level = 2'd0;

        // Start delay, level 0
        do_reset(2'd0, 1'b1);
        chk("l0_speed", lava_speed, 1);
        for (int i = 1; i <= 4; i++) tick(1'b0, 1'b0, 1'b0);
        chk("idle_active", lava_active, 0);
        tick(1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 121; j++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (j <= 120) chk("delay_x", lava_wall_x, 0);
            if (j == 119) chk("delay_active_119", lava_active, 0);
            if (j == 120) chk("delay_active_120", lava_active, 1);
            if (j == 121) chk("first_move_x", lava_wall_x, 1);
        end

        // Boost stack and decay
        tick(1'b0, 1'b1, 1'b0);
        chk("boost1_speed", lava_speed, 2);
        chk("boost1_x", lava_wall_x, 2);
        tick(1'b0, 1'b1, 1'b0);
        chk("boost2_speed", lava_speed, 3);
        tick(1'b0, 1'b1, 1'b0);
        chk("boost3_speed", lava_speed, 4);
        chk("boost3_x", lava_wall_x, 7);
        for (int k = 1; k <= 120; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (k == 59)  chk("decay_59", lava_speed, 4);
            if (k == 60)  chk("decay_60", lava_speed, 3);
            if (k == 119) chk("decay_119", lava_speed, 3);
            if (k == 120) begin
                chk("decay_120", lava_speed, 2);
                chk("decay_x", lava_wall_x, 427);
            end
        end

        // Clamp at the right edge, level 1, boost held every tick
        do_reset(2'd1, 1'b0);
        chk("l1_speed", lava_speed, 2);
        tick(1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 120; j++) tick(1'b0, 1'b0, 1'b0);
        chk("l1_active", lava_active, 1);
        for (int k = 1; k <= 85; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (k == 7)  chk("ramp_x_7", lava_wall_x, 35);
            if (k == 81) begin
                chk("pre_clamp_x", lava_wall_x, 627);
                chk("sat_speed", lava_speed, 8);
            end
            if (k == 82) chk("clamp_x", lava_wall_x, 630);
            if (k == 85) begin
                chk("halt_x", lava_wall_x, 630);
                chk("halt_active", lava_active, 1);
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_x", lava_wall_x, 0);
        chk("midrst_active", lava_active, 0);
        rst = 1'b0;

        // Masked level
        do_reset(2'd2, 1'b0);
        hit_base = hit_cnt;
        for (int k = 1; k <= 500; k++) tick(1'b1, 1'b1, 1'b0);
        chk("dis_hits", hit_cnt - hit_base, 0);
        chk("dis_x", lava_wall_x, 0);
        chk("dis_active", lava_active, 0);
        chk("dis_caught", player_caught, 0);
        chk("dis_speed", lava_speed, 3);

        // Hit and caught
        do_reset(2'd0, 1'b0);
        player_x = 10'd50;
        tick(1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 120; j++) tick(1'b0, 1'b0, 1'b0);
        hit_base = hit_cnt;
        for (int k = 1; k <= 50; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (k == 39) begin
                chk("pre_hit_cnt", hit_cnt - hit_base, 0);
                chk("pre_hit_caught", player_caught, 0);
            end
            if (k == 40) begin
                chk("hit_x", lava_wall_x, 40);
                chk("hit_cnt", hit_cnt - hit_base, 1);
                chk("hit_caught", player_caught, 1);
            end
        end
        chk("hit_once", hit_cnt - hit_base, 1);
        chk("caught_sticky", player_caught, 1);
        level = 2'd1;
        @(posedge clk);
        #1;
        chk("lvlchg_caught", player_caught, 0);
        chk("lvlchg_x", lava_wall_x, 0);
        chk("lvlchg_active", lava_active, 0);
        player_x = 10'd1023;

        // Freeze during the delay and during advance
        do_reset(2'd0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 50; j++) tick(1'b0, 1'b0, 1'b0);
        for (int f = 1; f <= 30; f++) tick(1'b1, (f == 10), 1'b1);
        chk("frz_delay_active", lava_active, 0);
        chk("frz_delay_speed", lava_speed, 1);
        for (int j = 51; j <= 121; j++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (j == 119) chk("resume_active_119", lava_active, 0);
            if (j == 120) begin
                chk("resume_active_120", lava_active, 1);
                chk("resume_x_120", lava_wall_x, 0);
            end
            if (j == 121) chk("resume_x_121", lava_wall_x, 1);
        end
        for (int f = 1; f <= 5; f++) tick(1'b0, 1'b1, 1'b1);
        chk("frz_adv_x", lava_wall_x, 1);
        chk("frz_adv_speed", lava_speed, 1);
        tick(1'b0, 1'b0, 1'b0);
        chk("post_frz_x", lava_wall_x, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
